// File: rtl/kypd_scanner.sv
// Purpose : column-scan controller for a 4x4 keypad (PmodKYPD); debounces whole scans and reports one key.
// Latency : a press is reported on the cycle after the column-3 capture of the DebounceScans-th identical scan.
// Backpres: none; key_valid_o is a single-cycle strobe and is not held for a consumer.
//
// Ports:
//   clk_i         system clock
//   rst_ni        asynchronous active-low reset
//   row_i[3:0]    synchronized row lines, active low (0 = key closed in driven column)
//   col_o[3:0]    column drive, active low, at most one bit low
//   key_code_o    hex code of the last accepted key
//   key_valid_o   one-cycle strobe when a new key is accepted
//   key_pressed_o level, high while an accepted key is held
module kypd_scanner #(
  parameter int unsigned ColSettleCycles = 1000,
  parameter int unsigned DebounceScans   = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] row_i,
  output logic [3:0] col_o,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_pressed_o
);

  localparam int unsigned CntW = $clog2(ColSettleCycles);
  localparam int unsigned StbW = $clog2(DebounceScans + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(ColSettleCycles - 1);
  localparam logic [StbW-1:0] StbMax  = StbW'(DebounceScans);

  // The settle time has to cover the row synchronizer chain plus one cycle
  // of pad/keypad propagation, which never drops below 4 cycles.
  if (ColSettleCycles < 4) begin : g_bad_settle
    $error("kypd_scanner: ColSettleCycles must be at least 4");
  end
  if (DebounceScans < 1) begin : g_bad_debounce
    $error("kypd_scanner: DebounceScans must be at least 1");
  end

  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_KEY   = 2'd1,
    RES_MULTI = 2'd2
  } res_kind_e;

  // Keypad legend, indexed by {col[1:0], row[1:0]}.
  function automatic logic [3:0] key_map(input logic [3:0] idx);
    logic [3:0] code;
    case (idx)
      4'd0:    code = 4'h1;
      4'd1:    code = 4'h4;
      4'd2:    code = 4'h7;
      4'd3:    code = 4'h0;
      4'd4:    code = 4'h2;
      4'd5:    code = 4'h5;
      4'd6:    code = 4'h8;
      4'd7:    code = 4'hF;
      4'd8:    code = 4'h3;
      4'd9:    code = 4'h6;
      4'd10:   code = 4'h9;
      4'd11:   code = 4'hE;
      4'd12:   code = 4'hA;
      4'd13:   code = 4'hB;
      4'd14:   code = 4'hC;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  // Scan sequencing state
  logic            running;     // low only between reset release and the first edge
  logic [1:0]      col_idx;
  logic [CntW-1:0] settle_cnt;
  logic [11:0]     row_acc;     // closed-key bits of columns 0..2 of the current scan

  // Debounce state
  res_kind_e       cand_kind;
  logic [3:0]      cand_code;
  logic [StbW-1:0] stable_cnt;

  // Scan evaluation (only meaningful on the column-3 capture edge)
  logic [15:0]     scan_bits;
  logic [1:0]      hit_cnt;     // saturates at 2: only none/one/many matters
  logic [3:0]      hit_idx;
  res_kind_e       res_kind;
  logic [3:0]      res_code;
  logic            same_res;
  logic [StbW-1:0] next_stable;
  logic            slot_end;
  logic            scan_end;

  always_comb begin
    scan_bits = {~row_i, row_acc};
    hit_cnt   = 2'd0;
    hit_idx   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (scan_bits[i]) begin
        hit_idx = i[3:0];
        if (hit_cnt != 2'd2) begin
          hit_cnt = hit_cnt + 2'd1;
        end
      end
    end

    case (hit_cnt)
      2'd0:    res_kind = RES_NONE;
      2'd1:    res_kind = RES_KEY;
      default: res_kind = RES_MULTI;
    endcase
    res_code = key_map(hit_idx);

    // A key result only matches the candidate if the code matches as well.
    same_res = (res_kind == cand_kind) &&
               ((res_kind != RES_KEY) || (res_code == cand_code));

    if (!same_res) begin
      next_stable = StbW'(1);
    end else if (stable_cnt == StbMax) begin
      next_stable = StbMax;
    end else begin
      next_stable = stable_cnt + StbW'(1);
    end

    slot_end = running && (settle_cnt == CntLast);
    scan_end = slot_end && (col_idx == 2'd3);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      running       <= 1'b0;
      col_idx       <= 2'd0;
      settle_cnt    <= '0;
      row_acc       <= '0;
      col_o         <= 4'b1111;
      cand_kind     <= RES_NONE;
      cand_code     <= 4'h0;
      stable_cnt    <= '0;
      key_code_o    <= 4'h0;
      key_valid_o   <= 1'b0;
      key_pressed_o <= 1'b0;
    end else begin
      key_valid_o <= 1'b0;

      if (!running) begin
        // First edge after reset: start driving column 0.
        running    <= 1'b1;
        col_idx    <= 2'd0;
        settle_cnt <= '0;
        col_o      <= 4'b1110;
      end else if (slot_end) begin
        // Last cycle of the slot: capture rows, move to the next column.
        settle_cnt <= '0;
        col_idx    <= col_idx + 2'd1;
        col_o      <= ~(4'b0001 << (col_idx + 2'd1));
        case (col_idx)
          2'd0:    row_acc[3:0]  <= ~row_i;
          2'd1:    row_acc[7:4]  <= ~row_i;
          2'd2:    row_acc[11:8] <= ~row_i;
          default: row_acc       <= '0;
        endcase
      end else begin
        settle_cnt <= settle_cnt + CntW'(1);
      end

      if (scan_end) begin
        cand_kind  <= res_kind;
        cand_code  <= res_code;
        stable_cnt <= next_stable;

        if (next_stable == StbMax) begin
          if (res_kind == RES_KEY) begin
            // Saturation plus the held-code compare keeps a held key from re-strobing.
            if (!key_pressed_o || (key_code_o != res_code)) begin
              key_code_o    <= res_code;
              key_pressed_o <= 1'b1;
              key_valid_o   <= 1'b1;
            end
          end else begin
            // Ghosted (multi-key) scans read as released; the last code is kept.
            key_pressed_o <= 1'b0;
          end
        end
      end
    end
  end

endmodule
